// File: rtl/sfu_pkg.sv
// Shared types and helpers for the multi-lane accumulate/ReLU unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// PSUM_BW fixes the lane width seen by sat_add and the lane slice helper.
// sfu_multi's psum_bw parameter defaults to it and must match it.
package sfu_pkg;

    localparam int PSUM_BW = 16;

    typedef logic signed [PSUM_BW-1:0] psum_t;

    localparam psum_t SAT_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam psum_t SAT_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    typedef struct packed {
        logic  clamped;
        psum_t sum;
    } sat_res_t;

    // One extra bit of headroom is enough for the sum of two operands.
    // The two top bits disagree exactly when the true sum leaves the
    // representable range. Bit PSUM_BW then gives the direction.
    function automatic sat_res_t sat_add(input psum_t a, input psum_t b);
        logic [PSUM_BW:0] s;
        sat_res_t         r;
        s         = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
        r.clamped = s[PSUM_BW] ^ s[PSUM_BW-1];
        if (!r.clamped) begin
            r.sum = s[PSUM_BW-1:0];
        end else if (s[PSUM_BW]) begin
            r.sum = SAT_MIN;
        end else begin
            r.sum = SAT_MAX;
        end
        return r;
    endfunction

    // Lowest bit of lane c in a packed multi-lane bus.
    function automatic int lane_lsb(input int c);
        return c * PSUM_BW;
    endfunction

endpackage

// File: rtl/sfu_lane.sv
// One channel: accumulator, saturating add, sticky clamp flag, and ReLU/bypass output register.
// Latency: 1 cycle from the final-tap beat to sfp_out/sat_flag.
// Backpressure: none internally. The parent only raises beat when the beat is accepted.
//
// Ports:
//   clk, reset (async, active-low)
//   clear      abort the window (accumulator and sticky bit go to zero)
//   beat       psum_in is accepted this cycle
//   first/last beat is the first/last tap of the window
//   relu_en    clamp negative results to zero (only looked at on the last tap)
//   psum_in    this lane's partial sum
//   sfp_out    finished value
//   sat_flag   a clamp happened somewhere in the finished window
module sfu_lane
    import sfu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               beat,
    input  logic               first,
    input  logic               last,
    input  logic               relu_en,
    input  logic [PSUM_BW-1:0] psum_in,
    output logic [PSUM_BW-1:0] sfp_out,
    output logic               sat_flag
);

    psum_t    acc;
    logic     sticky;
    sat_res_t add_r;
    psum_t    sum_nxt;
    logic     clamp_nxt;
    psum_t    res_out;

    // The first tap loads the value directly. This removes the need for a
    // clear cycle between pixels. A single-tap window is both first and last.
    always_comb begin
        add_r     = sat_add(acc, psum_t'(psum_in));
        sum_nxt   = first ? psum_t'(psum_in) : add_r.sum;
        clamp_nxt = first ? 1'b0 : add_r.clamped;
        res_out   = (relu_en && sum_nxt[PSUM_BW-1]) ? '0 : sum_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            sticky   <= 1'b0;
            sfp_out  <= '0;
            sat_flag <= 1'b0;
        end else if (clear) begin
            acc    <= '0;
            sticky <= 1'b0;
        end else if (beat) begin
            if (last) begin
                acc      <= '0;
                sticky   <= 1'b0;
                sfp_out  <= res_out;
                sat_flag <= sticky | clamp_nxt;
            end else begin
                acc    <= sum_nxt;
                sticky <= sticky | clamp_nxt;
            end
        end
    end

endmodule

// File: rtl/sfu_multi.sv
// Multi-lane psum accumulator: sums num_taps beats per pixel with saturation, optional ReLU.
// Latency: 1 cycle from the final-tap accept to out_valid.
// Backpressure: a one-entry output buffer. Only the final tap stalls, while that buffer is full and not draining.
//
// Ports:
//   clk, reset (async, active-low)
//   clear              abort the current tap window (output buffer untouched)
//   relu_en            sampled with the final tap
//   in_valid/in_ready  psum_in handshake. Lane c is psum_in[c*psum_bw +: psum_bw].
//   out_valid/out_ready sfp_out handshake. The packing is the same as psum_in.
//   sat_flag           per-lane "clamped during this pixel"
//   tap_cnt            taps accepted so far in the current window
module sfu_multi
    import sfu_pkg::*;
#(
    parameter int psum_bw  = PSUM_BW,
    parameter int col      = 8,
    parameter int num_taps = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          relu_en,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [col*psum_bw-1:0]        psum_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [col*psum_bw-1:0]        sfp_out,
    output logic [col-1:0]                sat_flag,
    output logic [$clog2(num_taps+1)-1:0] tap_cnt
);

    localparam int            TW       = $clog2(num_taps + 1);
    localparam logic [TW-1:0] LAST_TAP = TW'(num_taps - 1);

    logic first_tap;
    logic last_tap;
    logic beat;

    assign first_tap = (tap_cnt == '0);
    assign last_tap  = (tap_cnt == LAST_TAP);

    // Only the beat that would overwrite the output buffer has to wait.
    // A draining buffer (out_ready high) can be refilled in the same cycle.
    assign in_ready = !clear && !(last_tap && out_valid && !out_ready);
    assign beat     = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_cnt <= '0;
        end else if (clear) begin
            tap_cnt <= '0;
        end else if (beat) begin
            tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else if (beat && last_tap) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_lane
        sfu_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .beat     (beat),
            .first    (first_tap),
            .last     (last_tap),
            .relu_en  (relu_en),
            .psum_in  (psum_in[lane_lsb(c) +: PSUM_BW]),
            .sfp_out  (sfp_out[lane_lsb(c) +: PSUM_BW]),
            .sat_flag (sat_flag[c])
        );
    end

endmodule

// File: tb/tb_sfu_multi.sv
// Self-checking bench for sfu_multi (col=4, num_taps=9, psum_bw=16).
// Directed scenarios followed by random traffic, all checked against an integer reference model.
module tb_sfu_multi;

    localparam int BW = 16;
    localparam int NC = 4;
    localparam int NT = 9;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          relu_en;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   psum_in;
    logic          out_valid;
    logic          out_ready;
    logic [63:0]   sfp_out;
    logic [3:0]    sat_flag;
    logic [3:0]    tap_cnt;

    sfu_multi #(.psum_bw(BW), .col(NC), .num_taps(NT)) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .psum_in   (psum_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sfp_out   (sfp_out),
        .sat_flag  (sat_flag),
        .tap_cnt   (tap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain integer arithmetic per lane.
    int          m_acc [NC];
    bit          m_st  [NC];
    int          m_tap;
    bit          m_ovld;
    logic [63:0] m_out;
    logic [3:0]  m_sat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] x);
        return {x, x, x, x};
    endfunction

    task automatic model_reset();
        for (int l = 0; l < NC; l++) begin
            m_acc[l] = 0;
            m_st[l]  = 1'b0;
        end
        m_tap  = 0;
        m_ovld = 1'b0;
        m_out  = '0;
        m_sat  = '0;
    endtask

    // Check the DUT against the model at the negedge. Then advance the model
    // across the next posedge, using the inputs that the DUT sees there.
    task automatic step();
        bit rdy_e;
        bit acc_e;
        bit last_e;
        @(negedge clk);
        rdy_e = !clear && (m_tap != NT-1 || !m_ovld || out_ready);
        chk("in_ready",  in_ready,  rdy_e);
        chk("out_valid", out_valid, m_ovld);
        chk("tap_cnt",   tap_cnt,   m_tap);
        chk("sfp_out",   sfp_out,   m_out);
        chk("sat_flag",  sat_flag,  m_sat);
        acc_e  = in_valid && rdy_e;
        last_e = (m_tap == NT-1);
        @(posedge clk);
        if (clear) begin
            m_tap = 0;
            for (int l = 0; l < NC; l++) begin
                m_acc[l] = 0;
                m_st[l]  = 1'b0;
            end
        end else if (acc_e) begin
            for (int l = 0; l < NC; l++) begin
                int x;
                int s;
                bit cl;
                x  = int'($signed(psum_in[l*BW +: BW]));
                s  = (m_tap == 0) ? x : m_acc[l] + x;
                cl = 1'b0;
                if (s > 32767) begin
                    s  = 32767;
                    cl = 1'b1;
                end else if (s < -32768) begin
                    s  = -32768;
                    cl = 1'b1;
                end
                if (last_e) begin
                    m_out[l*BW +: BW] = (relu_en && s < 0) ? 16'd0 : 16'(s);
                    m_sat[l] = m_st[l] | cl;
                    m_acc[l] = 0;
                    m_st[l]  = 1'b0;
                end else begin
                    m_acc[l] = s;
                    m_st[l]  = m_st[l] | cl;
                end
            end
            m_tap = last_e ? 0 : m_tap + 1;
        end
        if (acc_e && last_e) m_ovld = 1'b1;
        else if (out_ready)  m_ovld = 1'b0;
        #1;
    endtask

    task automatic drive(input bit v, input logic [63:0] d, input bit ordy, input bit relu, input bit clr);
        in_valid  = v;
        psum_in   = d;
        out_ready = ordy;
        relu_en   = relu;
        clear     = clr;
        step();
    endtask

    task automatic pixel(input logic [63:0] d, input bit relu);
        for (int i = 0; i < NT; i++) drive(1'b1, d, 1'b1, relu, 1'b0);
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        reset = 1'b0;
        #1;
        chk({tag, "_ovld"}, out_valid, 1'b0);
        chk({tag, "_tap"},  tap_cnt,   4'd0);
        chk({tag, "_out"},  sfp_out,   64'd0);
        chk({tag, "_sat"},  sat_flag,  4'd0);
        model_reset();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        clear     = 1'b0;
        relu_en   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        psum_in   = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_ovld", out_valid, 1'b0);
        chk("rst_tap",  tap_cnt,   4'd0);
        chk("rst_out",  sfp_out,   64'd0);
        chk("rst_sat",  sat_flag,  4'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Nine beats of +1 on every lane, with ReLU enabled.
        pixel(rep4(16'd1), 1'b1);
        chk("ones_val",  sfp_out,   rep4(16'd9));
        chk("ones_ovld", out_valid, 1'b1);
        chk("ones_sat",  sat_flag,  4'd0);
        chk("ones_tap",  tap_cnt,   4'd0);

        // Lane 0 gets -5 on each beat: pass-through first, then ReLU.
        pixel({16'd1, 16'd1, 16'd1, 16'hFFFB}, 1'b0);
        chk("neg_pass", sfp_out, {16'd9, 16'd9, 16'd9, 16'hFFD3});
        pixel({16'd1, 16'd1, 16'd1, 16'hFFFB}, 1'b1);
        chk("neg_relu", sfp_out, {16'd9, 16'd9, 16'd9, 16'h0000});

        // Positive and negative saturation on lane 1.
        for (int i = 0; i < NT; i++)
            drive(1'b1, (i < 2) ? 64'h0000_0000_7000_0000 : 64'd0, 1'b1, 1'b0, 1'b0);
        chk("satp_val", sfp_out[31:16], 16'h7FFF);
        chk("satp_flg", sat_flag, 4'b0010);
        for (int i = 0; i < NT; i++)
            drive(1'b1, (i < 2) ? 64'h0000_0000_9000_0000 : 64'd0, 1'b1, 1'b1, 1'b0);
        chk("satn_val", sfp_out[31:16], 16'h0000);
        for (int i = 0; i < NT; i++)
            drive(1'b1, (i < 2) ? 64'h0000_0000_9000_0000 : 64'd0, 1'b1, 1'b0, 1'b0);
        chk("satn_raw", sfp_out[31:16], 16'h8000);
        chk("satn_flg", sat_flag, 4'b0010);

        // Backpressure: A is held while B's final tap waits.
        pixel(rep4(16'd3), 1'b0);
        for (int i = 0; i < NT-1; i++) drive(1'b1, rep4(16'd4), 1'b0, 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        chk("bp_stall", in_ready, 1'b0);
        chk("bp_hold",  sfp_out,  rep4(16'd27));
        drive(1'b1, rep4(16'd4), 1'b0, 1'b0, 1'b0);
        drive(1'b1, rep4(16'd4), 1'b0, 1'b0, 1'b0);
        chk("bp_held2", sfp_out, rep4(16'd27));
        drive(1'b1, rep4(16'd4), 1'b1, 1'b0, 1'b0);
        chk("bp_b_val",  sfp_out,   rep4(16'd36));
        chk("bp_b_ovld", out_valid, 1'b1);
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        // Clear in the middle of a window, with a coincident beat.
        for (int i = 0; i < 5; i++) drive(1'b1, rep4(16'd7), 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        clear    = 1'b1;
        #1;
        chk("clr_rdy", in_ready, 1'b0);
        drive(1'b1, rep4(16'd7), 1'b1, 1'b0, 1'b1);
        chk("clr_tap", tap_cnt, 4'd0);
        pixel(rep4(16'd2), 1'b0);
        chk("clr_val", sfp_out, rep4(16'd18));

        // Async reset mid-window, and again while out_valid is held.
        for (int i = 0; i < 4; i++) drive(1'b1, rep4(16'd5), 1'b1, 1'b0, 1'b0);
        async_reset_check("arst_mid");
        pixel(rep4(16'd6), 1'b0);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        async_reset_check("arst_ovld");
        pixel(rep4(16'hFFFF), 1'b0);
        chk("post_rst", sfp_out, rep4(16'hFFF7));

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [63:0] d;
            for (int l = 0; l < NC; l++) begin
                if ($urandom_range(0, 3) == 0) d[l*BW +: BW] = 16'($urandom);
                else d[l*BW +: BW] = 16'($urandom_range(0, 400)) - 16'd200;
            end
            drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) < 6,
                  1'($urandom), $urandom_range(0, 99) < 3);
        end
        drive(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
